// File: rtl/sram_bank_if.sv
// rtl/sram_bank_if.sv - request/response port bundle for the SRAM bank
interface sram_bank_if #(
    parameter int AW   = 4,
    parameter int COLS = 8
);
    logic            req_valid;
    logic            req_ready;
    logic            req_we;
    logic [AW-1:0]   req_addr;
    logic [COLS-1:0] req_wdata;
    logic            rsp_valid;
    logic            rsp_we;
    logic            rsp_err;
    logic [COLS-1:0] rsp_rdata;

    modport master (
        output req_valid, req_we, req_addr, req_wdata,
        input  req_ready, rsp_valid, rsp_we, rsp_err, rsp_rdata
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata,
        output req_ready, rsp_valid, rsp_we, rsp_err, rsp_rdata
    );
endinterface

// File: rtl/sram_bank.sv
// rtl/sram_bank.sv - clocked SRAM bank with precharge/access/sense controller
module sram_bank #(
    parameter int  ROWS      = 16,
    parameter int  COLS      = 8,
    parameter int  SENSE_CYC = 2,
    parameter real VDD       = 1.5,
    parameter real VSS       = 0.0,
    parameter real DV        = 0.3
) (
    input  logic       clk,
    input  logic       rst,
    sram_bank_if.slave bus,
    output real        wl  [0:ROWS-1],
    output real        bl  [0:COLS-1],
    output real        blb [0:COLS-1]
);
    localparam int AW = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int CW = (SENSE_CYC > 1) ? $clog2(SENSE_CYC) : 1;

    typedef enum logic [2:0] {IDLE, PRE, ACT, WR, RESP} state_t;

    state_t          state, next_state;
    logic            we_q;
    logic [AW-1:0]   addr_q;
    logic [COLS-1:0] wdata_q;
    logic [CW-1:0]   cnt;
    logic [COLS-1:0] mem [0:ROWS-1];
    logic [COLS-1:0] sensed;
    logic            accept;
    logic            in_range;

    assign accept   = (state == IDLE) && bus.req_valid && bus.req_ready;
    assign in_range = (int'(addr_q) < ROWS);

    function automatic real discharge(input real v);
        return (v - DV < VSS) ? VSS : v - DV;
    endfunction

    always_comb begin
        sensed = '0;
        for (int c = 0; c < COLS; c++) sensed[c] = (bl[c] > blb[c]);
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (accept) next_state = PRE;
            PRE:     if (!in_range) next_state = RESP;
                     else if (we_q) next_state = WR;
                     else           next_state = ACT;
            ACT:     if (cnt == CW'(SENSE_CYC - 1)) next_state = RESP;
            WR:      next_state = RESP;
            RESP:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= next_state;
    end

    // Analog and response outputs are registered from the current state, so
    // each phase becomes visible on the edge after the FSM enters it.
    always_ff @(posedge clk) begin
        if (rst) begin
            we_q          <= 1'b0;
            addr_q        <= '0;
            wdata_q       <= '0;
            cnt           <= '0;
            bus.req_ready <= 1'b1;
            bus.rsp_valid <= 1'b0;
            bus.rsp_we    <= 1'b0;
            bus.rsp_err   <= 1'b0;
            bus.rsp_rdata <= '0;
            for (int r = 0; r < ROWS; r++) begin
                mem[r] <= '0;
                wl[r]  <= VSS;
            end
            for (int c = 0; c < COLS; c++) begin
                bl[c]  <= VDD;
                blb[c] <= VDD;
            end
        end else begin
            if (accept) begin
                we_q    <= bus.req_we;
                addr_q  <= bus.req_addr;
                wdata_q <= bus.req_wdata;
            end
            if (state == PRE)      cnt <= '0;
            else if (state == ACT) cnt <= cnt + 1'b1;

            bus.req_ready <= (next_state == IDLE);
            bus.rsp_valid <= 1'b0;

            for (int r = 0; r < ROWS; r++)
                wl[r] <= ((state == ACT || state == WR) && r == int'(addr_q)) ? VDD : VSS;

            case (state)
                ACT: begin
                    for (int c = 0; c < COLS; c++) begin
                        if (mem[addr_q][c]) begin
                            bl[c]  <= VDD;
                            blb[c] <= discharge(blb[c]);
                        end else begin
                            bl[c]  <= discharge(bl[c]);
                            blb[c] <= VDD;
                        end
                    end
                end
                WR: begin
                    for (int c = 0; c < COLS; c++) begin
                        bl[c]  <= wdata_q[c] ? VDD : VSS;
                        blb[c] <= wdata_q[c] ? VSS : VDD;
                    end
                    mem[addr_q] <= wdata_q;
                end
                RESP: begin
                    bus.rsp_valid <= 1'b1;
                    bus.rsp_we    <= we_q;
                    bus.rsp_err   <= !in_range;
                    bus.rsp_rdata <= (we_q || !in_range) ? '0 : sensed;
                    for (int c = 0; c < COLS; c++) begin
                        bl[c]  <= VDD;
                        blb[c] <= VDD;
                    end
                end
                default: begin
                    for (int c = 0; c < COLS; c++) begin
                        bl[c]  <= VDD;
                        blb[c] <= VDD;
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_sram_bank.sv
// tb/tb_sram_bank.sv - directed self-checking bench for sram_bank
module tb_sram_bank;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    sram_bank_if #(.AW(4), .COLS(8)) b16 ();
    sram_bank_if #(.AW(4), .COLS(8)) b12 ();

    real wl16 [0:15];
    real bl16 [0:7];
    real blb16 [0:7];
    real wl12 [0:11];
    real bl12 [0:7];
    real blb12 [0:7];

    sram_bank #(.ROWS(16)) u16 (.clk(clk), .rst(rst), .bus(b16), .wl(wl16), .bl(bl16), .blb(blb16));
    sram_bank #(.ROWS(12)) u12 (.clk(clk), .rst(rst), .bus(b12), .wl(wl12), .bl(bl12), .blb(blb12));

    logic [15:0] hi16, hi12;
    always_comb begin
        hi16 = '0;
        hi12 = '0;
        for (int r = 0; r < 16; r++) hi16[r] = (wl16[r] > 0.75);
        for (int r = 0; r < 12; r++) hi12[r] = (wl12[r] > 0.75);
    end

    int  errors, checks;
    real snap_bl [0:7][0:7];
    real snap_blb [0:7][0:7];
    real snap_wla [0:7];

    function automatic bit near(input real a, input real b);
        return (a - b < 1.0e-6) && (b - a < 1.0e-6);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_r(input string tag, input real obs, input real exp);
        checks++;
        assert (near(obs, exp) === 1'b1) else begin
            errors++;
            $error("FAIL %s observed=%f expected=%f", tag, obs, exp);
        end
    endtask

    task automatic txn(input bit sel, input bit we, input logic [3:0] addr, input logic [7:0] wdata,
                       output logic [7:0] rdata, output logic err, output logic rwe, output int lat,
                       output logic [15:0] hit, output int rdy_hi, output logic after_v,
                       output logic after_we);
        int g;
        g = 0;
        if (sel) begin
            b12.req_valid = 1'b1; b12.req_we = we; b12.req_addr = addr; b12.req_wdata = wdata;
        end else begin
            b16.req_valid = 1'b1; b16.req_we = we; b16.req_addr = addr; b16.req_wdata = wdata;
        end
        while (!(sel ? b12.req_ready : b16.req_ready) && g < 20) begin
            @(posedge clk); #1; g++;
        end
        @(posedge clk); #1;
        b12.req_valid = 1'b0;
        b16.req_valid = 1'b0;
        lat = 0; hit = '0; rdy_hi = 0; rdata = 'x; err = 'x; rwe = 'x;
        for (int k = 1; k <= 20; k++) begin
            @(posedge clk); #1;
            hit |= sel ? hi12 : hi16;
            if (k < 8) begin
                snap_wla[k] = wl16[addr];
                for (int c = 0; c < 8; c++) begin
                    snap_bl[k][c]  = bl16[c];
                    snap_blb[k][c] = blb16[c];
                end
            end
            if (sel ? b12.rsp_valid : b16.rsp_valid) begin
                lat   = k;
                rdata = sel ? b12.rsp_rdata : b16.rsp_rdata;
                err   = sel ? b12.rsp_err : b16.rsp_err;
                rwe   = sel ? b12.rsp_we : b16.rsp_we;
                break;
            end
            if (sel ? b12.req_ready : b16.req_ready) rdy_hi++;
        end
        @(posedge clk); #1;
        after_v  = sel ? b12.rsp_valid : b16.rsp_valid;
        after_we = sel ? b12.rsp_we : b16.rsp_we;
    endtask

    logic [7:0]  rd, pat, d;
    logic        er, rw, av, aw;
    logic [15:0] hit;
    int          lat, rh, mm, seen;
    bit          bwe [0:5] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    logic [3:0]  badr [0:5] = '{4'd7, 4'd7, 4'd8, 4'd8, 4'd7, 4'd7};
    logic [7:0]  bdat [0:5] = '{8'h11, 8'h00, 8'h22, 8'h00, 8'h33, 8'h00};
    int          nacc, nrsp, last_acc;
    logic        pend;

    initial begin
        #100000;
        $display("FAIL watchdog expired observed=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        errors = 0; checks = 0;
        rst = 1'b1;
        b16.req_valid = 1'b0; b16.req_we = 1'b0; b16.req_addr = '0; b16.req_wdata = '0;
        b12.req_valid = 1'b0; b12.req_we = 1'b0; b12.req_addr = '0; b12.req_wdata = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        chk("rst_ready", b16.req_ready, 1);
        chk("rst_valid", b16.rsp_valid, 0);
        chk("rst_rdata", b16.rsp_rdata, 0);
        chk("rst_err", b16.rsp_err, 0);
        chk("rst_wl", hi16, 0);
        chk_r("rst_wl0", wl16[0], 0.0);
        chk_r("rst_bl0", bl16[0], 1.5);
        chk_r("rst_blb7", blb16[7], 1.5);

        // fresh read of row 3
        txn(0, 0, 4'd3, 8'h00, rd, er, rw, lat, hit, rh, av, aw);
        chk("rd3_lat", lat, 4);
        chk("rd3_data", rd, 8'h00);
        chk("rd3_err", er, 0);
        chk("rd3_ready_low", rh, 0);
        chk("rd3_pulse", av, 0);
        chk("rd3_wl", hit, 16'h0008);

        // write A5 to row 5, check WR bitlines
        pat = 8'hA5;
        txn(0, 1, 4'd5, pat, rd, er, rw, lat, hit, rh, av, aw);
        chk("wr5_lat", lat, 3);
        chk("wr5_we", rw, 1);
        chk("wr5_rdata", rd, 0);
        chk("wr5_pulse", av, 0);
        chk("wr5_we_held", aw, 1);
        chk("wr5_wl", hit, 16'h0020);
        chk_r("wr5_wl5", snap_wla[2], 1.5);
        mm = 0;
        for (int c = 0; c < 8; c++) begin
            if (!near(snap_bl[2][c], pat[c] ? 1.5 : 0.0)) mm++;
            if (!near(snap_blb[2][c], pat[c] ? 0.0 : 1.5)) mm++;
        end
        chk("wr5_bitlines", mm, 0);

        txn(0, 0, 4'd5, 8'h00, rd, er, rw, lat, hit, rh, av, aw);
        chk("rd5_data", rd, 8'hA5);
        chk("rd5_lat", lat, 4);
        chk("rd5_we_held", aw, 0);
        chk_r("rd5_first_act_blb0", snap_blb[2][0], 1.2);
        mm = 0;
        for (int c = 0; c < 8; c++) begin
            if (!near(snap_bl[3][c], pat[c] ? 1.5 : 0.9)) mm++;
            if (!near(snap_blb[3][c], pat[c] ? 0.9 : 1.5)) mm++;
        end
        chk("rd5_final_act", mm, 0);

        // walk all rows
        for (int r = 0; r < 16; r++) begin
            d = 8'(r) ^ 8'h3C;
            txn(0, 1, 4'(r), d, rd, er, rw, lat, hit, rh, av, aw);
            chk("walk_wr_wl", hit, 16'h0001 << r);
        end
        for (int r = 0; r < 16; r++) begin
            d = 8'(r) ^ 8'h3C;
            txn(0, 0, 4'(r), 8'h00, rd, er, rw, lat, hit, rh, av, aw);
            chk("walk_rd_data", rd, d);
            chk("walk_rd_wl", hit, 16'h0001 << r);
        end

        // 12-row bank: errors beyond the last row
        for (int r = 0; r < 12; r++)
            txn(1, 1, 4'(r), 8'(r * 17), rd, er, rw, lat, hit, rh, av, aw);
        txn(1, 0, 4'd11, 8'h00, rd, er, rw, lat, hit, rh, av, aw);
        chk("r12_rd11", rd, 8'd187);
        txn(1, 0, 4'd13, 8'h00, rd, er, rw, lat, hit, rh, av, aw);
        chk("r12_rd13_lat", lat, 2);
        chk("r12_rd13_err", er, 1);
        chk("r12_rd13_rdata", rd, 0);
        chk("r12_rd13_wl", hit, 0);
        txn(1, 1, 4'd14, 8'hFF, rd, er, rw, lat, hit, rh, av, aw);
        chk("r12_wr14_err", er, 1);
        chk("r12_wr14_we", rw, 1);
        chk("r12_wr14_lat", lat, 2);
        chk("r12_wr14_wl", hit, 0);
        mm = 0;
        for (int r = 0; r < 12; r++) begin
            txn(1, 0, 4'(r), 8'h00, rd, er, rw, lat, hit, rh, av, aw);
            if (rd !== 8'(r * 17) || er !== 1'b0) mm++;
        end
        chk("r12_rows_intact", mm, 0);

        // reset during the access phase of a read
        b16.req_valid = 1'b1; b16.req_we = 1'b0; b16.req_addr = 4'd3;
        @(posedge clk); #1;
        b16.req_valid = 1'b0;
        repeat (2) begin @(posedge clk); #1; end
        chk("rstact_in_act", hi16, 16'h0008);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("rstact_valid", b16.rsp_valid, 0);
        chk("rstact_ready", b16.req_ready, 1);
        chk("rstact_rdata", b16.rsp_rdata, 0);
        chk("rstact_wl", hi16, 0);
        chk_r("rstact_bl3", bl16[3], 1.5);
        seen = 0;
        repeat (6) begin @(posedge clk); #1; if (b16.rsp_valid) seen++; end
        chk("rstact_no_rsp", seen, 0);

        // reset during the write phase
        b16.req_valid = 1'b1; b16.req_we = 1'b1; b16.req_addr = 4'd2; b16.req_wdata = 8'hFF;
        @(posedge clk); #1;
        b16.req_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("rstwr_valid", b16.rsp_valid, 0);
        chk("rstwr_we", b16.rsp_we, 0);
        seen = 0;
        repeat (6) begin @(posedge clk); #1; if (b16.rsp_valid) seen++; end
        chk("rstwr_no_rsp", seen, 0);
        txn(0, 0, 4'd2, 8'h00, rd, er, rw, lat, hit, rh, av, aw);
        chk("rstwr_rd2", rd, 8'h00);

        // back-to-back with req_valid held high
        nacc = 0; nrsp = 0; last_acc = 0;
        b16.req_valid = 1'b1; b16.req_we = bwe[0]; b16.req_addr = badr[0]; b16.req_wdata = bdat[0];
        for (int cyc = 0; cyc < 60; cyc++) begin
            pend = b16.req_valid && b16.req_ready;
            @(posedge clk); #1;
            if (pend) begin
                if (nacc > 0) chk("b2b_gap", cyc - last_acc, bwe[nacc-1] ? 4 : 5);
                last_acc = cyc;
                nacc++;
                if (nacc < 6) begin
                    b16.req_we = bwe[nacc]; b16.req_addr = badr[nacc]; b16.req_wdata = bdat[nacc];
                end else begin
                    b16.req_valid = 1'b0;
                end
            end
            if (b16.rsp_valid) begin
                if (nrsp < 6) begin
                    chk("b2b_we", b16.rsp_we, bwe[nrsp]);
                    if (!bwe[nrsp]) chk("b2b_rdata", b16.rsp_rdata, bdat[nrsp-1]);
                end
                nrsp++;
            end
        end
        chk("b2b_accepts", nacc, 6);
        chk("b2b_responses", nrsp, 6);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
